source_pool_alloc: RTL and testbench

- Sits directly downstream of the WQE source-apply stage. Consumes its {len, id} apply beats.
- Carves each request out of a ring-organised source pool of POOL_UNITS units and issues a grant carrying the base offset.
- Returns credits on release and drives the `source_available` count back to the apply stage.

---
 rtl/source_pool_pkg.sv | 10 +
 rtl/source_pool_skid2.sv | 40 ++++
 rtl/source_pool_alloc.sv | 127 ++++++++++++
 tb/tb_source_pool_alloc.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/source_pool_pkg.sv
// source_pool_pkg: allocator FSM encoding, {len, id} apply-beat field layout and pool size default
// shared between the WQE source-apply stage and the source-pool allocator.
package source_pool_pkg;
  typedef enum logic [1:0] {IDLE, WAIT_FREE, GRANT} state_t;
  localparam int POOL_UNITS_DEF = 1024;
  localparam int REQ_ID_LSB     = 0;
  function automatic int req_len_lsb(input int id_width);
    return REQ_ID_LSB + id_width;
  endfunction
endpackage

// File: rtl/source_pool_skid2.sv
// source_pool_skid2: 2-entry input buffer; every valid beat is written while space remains,
// ready is a registered "buffer empty" so a producer with one cycle of read latency cannot overrun it.
module source_pool_skid2 #(
  parameter int W = 21
) (
  input  logic         sys_clk,
  input  logic         sys_rst,
  input  logic         push_i,
  input  logic [W-1:0] data_i,
  input  logic         pop_i,
  output logic [W-1:0] data_o,
  output logic         empty_o,
  output logic         ready_o
);
  logic [W-1:0] mem_q [2];
  logic         rd_q, wr_q, rdy_q;
  logic [1:0]   occ_q, occ_d;
  logic         push_ok, pop_ok;
  // A beat arriving with both entries held is dropped rather than overwriting the head.
  assign push_ok = push_i && occ_q != 2'd2;
  assign pop_ok  = pop_i && occ_q != 2'd0;
  assign occ_d   = occ_q + {1'b0, push_ok} - {1'b0, pop_ok};
  assign data_o  = mem_q[rd_q];
  assign empty_o = occ_q == 2'd0;
  assign ready_o = rdy_q;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      rd_q  <= 1'b0;
      wr_q  <= 1'b0;
      occ_q <= 2'd0;
      rdy_q <= 1'b1;
    end else begin
      rd_q  <= rd_q ^ pop_ok;
      wr_q  <= wr_q ^ push_ok;
      occ_q <= occ_d;
      rdy_q <= occ_d == 2'd0;
    end
  always_ff @(posedge sys_clk)
    if (push_ok) mem_q[wr_q] <= data_i;
endmodule

// File: rtl/source_pool_alloc.sv
// source_pool_alloc: carves WQE source requests out of a ring pool and grants base offsets.
// Define SOURCE_POOL_STATS_EN to build the grant and free-space stall counters.
module source_pool_alloc
  import source_pool_pkg::*;
#(
  parameter int WQE_INDEX_WIDTH   = 10,
  parameter int WQE_SOURCE_LENGTH = 11,
  parameter int POOL_ADDR_WIDTH   = 10,
  parameter int POOL_UNITS        = POOL_UNITS_DEF
) (
  input  logic                                         sys_clk,
  input  logic                                         sys_rst,
  input  logic                                         s_axis_req_valid,
  input  logic [WQE_INDEX_WIDTH+WQE_SOURCE_LENGTH-1:0] s_axis_req_id_len,
  output logic                                         s_axis_req_ready,
  output logic                                         m_axis_grant_valid,
  output logic [WQE_INDEX_WIDTH-1:0]                   m_axis_grant_id,
  output logic [POOL_ADDR_WIDTH-1:0]                   m_axis_grant_base,
  output logic [WQE_SOURCE_LENGTH-1:0]                 m_axis_grant_len,
  output logic                                         m_axis_grant_wrap,
  input  logic                                         m_axis_grant_ready,
  input  logic                                         s_rel_valid,
  input  logic [WQE_SOURCE_LENGTH-1:0]                 s_rel_len,
  output logic [WQE_SOURCE_LENGTH-1:0]                 source_available,
  output logic                                         rel_overflow_err,
  output logic [31:0]                                  stat_grant_cnt,
  output logic [31:0]                                  stat_stall_cnt
);
  localparam int IW      = WQE_INDEX_WIDTH;
  localparam int LW      = WQE_SOURCE_LENGTH;
  localparam int AW      = POOL_ADDR_WIDTH;
  localparam int SW      = LW + 1;
  localparam int LEN_LSB = req_len_lsb(IW);
  localparam logic [SW-1:0] PU = SW'(POOL_UNITS);
  state_t          state_q, state_d;
  logic [IW+LW-1:0] head;
  logic            empty, fits, load, hs, over;
  logic [IW-1:0]   head_id, id_q;
  logic [LW-1:0]   head_len, len_q, free_q, free_d;
  logic [AW-1:0]   base_q, wr_ptr_q, wr_ptr_d;
  logic            wrap_q, err_q;
  logic [SW-1:0]   ptr_sum, free_sum;
  source_pool_skid2 #(.W(IW + LW)) u_skid (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .push_i  (s_axis_req_valid),
    .data_i  (s_axis_req_id_len),
    .pop_i   (load),
    .data_o  (head),
    .empty_o (empty),
    .ready_o (s_axis_req_ready)
  );
  assign head_id  = head[REQ_ID_LSB +: IW];
  assign head_len = head[LEN_LSB +: LW];
  assign fits     = !empty && head_len <= free_q;
  assign hs       = state_q == GRANT && m_axis_grant_ready;
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    case (state_q)
      IDLE: begin
        load    = fits;
        state_d = fits ? GRANT : empty ? IDLE : WAIT_FREE;
      end
      WAIT_FREE: begin
        load    = fits;
        state_d = fits ? GRANT : WAIT_FREE;
      end
      GRANT: begin
        load    = hs && fits;
        state_d = !hs || fits ? GRANT : IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  // Release credits land in the same update as the allocation; the fit check only sees them next cycle.
  assign ptr_sum  = SW'(wr_ptr_q) + {1'b0, head_len};
  assign free_sum = {1'b0, free_q} - (load ? {1'b0, head_len} : '0) + (s_rel_valid ? {1'b0, s_rel_len} : '0);
  assign over     = free_sum > PU;
  assign free_d   = over ? LW'(POOL_UNITS) : LW'(free_sum);
  assign wr_ptr_d = load ? AW'(ptr_sum >= PU ? ptr_sum - PU : ptr_sum) : wr_ptr_q;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      state_q  <= IDLE;
      free_q   <= LW'(POOL_UNITS);
      wr_ptr_q <= '0;
      err_q    <= 1'b0;
      id_q     <= '0;
      base_q   <= '0;
      len_q    <= '0;
      wrap_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      free_q   <= free_d;
      wr_ptr_q <= wr_ptr_d;
      err_q    <= err_q | over;
      if (load) begin
        id_q   <= head_id;
        base_q <= wr_ptr_q;
        len_q  <= head_len;
        wrap_q <= ptr_sum > PU;
      end
    end
  assign m_axis_grant_valid = state_q == GRANT;
  assign m_axis_grant_id    = id_q;
  assign m_axis_grant_base  = base_q;
  assign m_axis_grant_len   = len_q;
  assign m_axis_grant_wrap  = wrap_q;
  assign source_available   = free_q;
  assign rel_overflow_err   = err_q;
`ifdef SOURCE_POOL_STATS_EN
  logic [31:0] grant_cnt_q, stall_cnt_q;
  always_ff @(posedge sys_clk or posedge sys_rst)
    if (sys_rst) begin
      grant_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      grant_cnt_q <= grant_cnt_q + {31'd0, hs};
      stall_cnt_q <= stall_cnt_q + {31'd0, state_q == WAIT_FREE};
    end
  assign stat_grant_cnt = grant_cnt_q;
  assign stat_stall_cnt = stall_cnt_q;
`else
  assign stat_grant_cnt = '0;
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_source_pool_alloc.sv
// tb_source_pool_alloc: scoreboard bench for the source-pool allocator; expected grants are queued
// as beats are driven and compared when the grant handshake completes.
module tb_source_pool_alloc;
  localparam int IW = 10, LW = 11, AW = 10, PU = 1024;
  logic           sys_clk = 1'b0, sys_rst = 1'b1;
  logic           s_axis_req_valid = 1'b0, s_axis_req_ready;
  logic [IW+LW-1:0] s_axis_req_id_len = '0;
  logic           m_axis_grant_valid, m_axis_grant_wrap, m_axis_grant_ready = 1'b0;
  logic [IW-1:0]  m_axis_grant_id;
  logic [AW-1:0]  m_axis_grant_base;
  logic [LW-1:0]  m_axis_grant_len, source_available, s_rel_len = '0;
  logic           s_rel_valid = 1'b0, rel_overflow_err;
  logic [31:0]    stat_grant_cnt, stat_stall_cnt;
  typedef struct packed {
    logic [IW-1:0] id;
    logic [AW-1:0] base;
    logic [LW-1:0] len;
    logic          wrap;
  } grant_t;
  grant_t exp_q[$];
  grant_t mon_a, mon_e;
  int checks = 0, errors = 0, grants = 0, mptr = 0, mfree = PU;
  source_pool_alloc dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .s_axis_req_valid(s_axis_req_valid), .s_axis_req_id_len(s_axis_req_id_len), .s_axis_req_ready(s_axis_req_ready),
    .m_axis_grant_valid(m_axis_grant_valid), .m_axis_grant_id(m_axis_grant_id), .m_axis_grant_base(m_axis_grant_base),
    .m_axis_grant_len(m_axis_grant_len), .m_axis_grant_wrap(m_axis_grant_wrap), .m_axis_grant_ready(m_axis_grant_ready),
    .s_rel_valid(s_rel_valid), .s_rel_len(s_rel_len), .source_available(source_available),
    .rel_overflow_err(rel_overflow_err), .stat_grant_cnt(stat_grant_cnt), .stat_stall_cnt(stat_stall_cnt)
  );
  always #5 sys_clk = ~sys_clk;
  always @(negedge sys_clk)
    if (!sys_rst && m_axis_grant_valid && m_axis_grant_ready) begin
      mon_a = {m_axis_grant_id, m_axis_grant_base, m_axis_grant_len, m_axis_grant_wrap};
      checks++;
      grants++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL grant_unexpected: got id=%0d base=%0d len=%0d wrap=%0b, none expected",
                 mon_a.id, mon_a.base, mon_a.len, mon_a.wrap);
      end else begin
        mon_e = exp_q.pop_front();
        if (mon_a !== mon_e) begin
          errors++;
          $display("FAIL grant_data: got id=%0d base=%0d len=%0d wrap=%0b, expected id=%0d base=%0d len=%0d wrap=%0b",
                   mon_a.id, mon_a.base, mon_a.len, mon_a.wrap, mon_e.id, mon_e.base, mon_e.len, mon_e.wrap);
        end
      end
    end
  task automatic send(input int len, input int id, input bit keep);
    grant_t e;
    if (keep) begin
      e.id   = IW'(id);
      e.base = AW'(mptr);
      e.len  = LW'(len);
      e.wrap = mptr + len > PU;
      exp_q.push_back(e);
      mptr  = (mptr + len) % PU;
      mfree = mfree - len;
    end
    s_axis_req_valid  = 1'b1;
    s_axis_req_id_len = {LW'(len), IW'(id)};
    @(posedge sys_clk); #1;
    s_axis_req_valid = 1'b0;
  endtask
  task automatic rel(input int len);
    s_rel_valid = 1'b1;
    s_rel_len   = LW'(len);
    mfree       = (mfree + len > PU) ? PU : mfree + len;
    @(posedge sys_clk); #1;
    s_rel_valid = 1'b0;
  endtask
  task automatic drain();
    int n = 0;
    m_axis_grant_ready = 1'b1;
    while ((exp_q.size() != 0 || m_axis_grant_valid) && n < 200) begin
      @(posedge sys_clk); #1;
      n++;
    end
    checks++;
    if (n >= 200) begin
      errors++;
      $display("FAIL drain_timeout: %0d grants still pending after %0d cycles, expected 0", exp_q.size(), n);
    end
  endtask
  task automatic test_reset();
    sys_rst = 1'b1;
    repeat (3) @(posedge sys_clk);
    #1 sys_rst = 1'b0;
    checks += 5;
    if (s_axis_req_ready !== 1'b1) begin errors++; $display("FAIL reset_ready: got %0b expected 1", s_axis_req_ready); end
    if (m_axis_grant_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b expected 0", m_axis_grant_valid); end
    if (source_available !== LW'(PU)) begin errors++; $display("FAIL reset_avail: got %0d expected %0d", source_available, PU); end
    if (rel_overflow_err !== 1'b0) begin errors++; $display("FAIL reset_err: got %0b expected 0", rel_overflow_err); end
    if ({m_axis_grant_id, m_axis_grant_base, m_axis_grant_len, m_axis_grant_wrap, stat_grant_cnt, stat_stall_cnt} !== '0) begin
      errors++;
      $display("FAIL reset_data: got id=%0d base=%0d len=%0d stats=%0d/%0d expected all 0",
               m_axis_grant_id, m_axis_grant_base, m_axis_grant_len, stat_grant_cnt, stat_stall_cnt);
    end
  endtask
  task automatic test_basic();
    m_axis_grant_ready = 1'b1;
    send(100, 5, 1);
    checks += 4;
    if (m_axis_grant_valid !== 1'b0) begin errors++; $display("FAIL basic_early: valid got %0b expected 0", m_axis_grant_valid); end
    @(posedge sys_clk); #1;
    if (m_axis_grant_valid !== 1'b1) begin errors++; $display("FAIL basic_latency: valid got %0b expected 1", m_axis_grant_valid); end
    if (m_axis_grant_base !== 10'd0 || m_axis_grant_len !== 11'd100) begin
      errors++; $display("FAIL basic_data: got base=%0d len=%0d expected base=0 len=100", m_axis_grant_base, m_axis_grant_len);
    end
    if (source_available !== 11'd924) begin errors++; $display("FAIL basic_avail: got %0d expected 924", source_available); end
    drain();
  endtask
  task automatic test_wrap();
    rel(100);
    send(900, 1, 1);
    drain();
    rel(900);
    send(50, 2, 1);
    @(posedge sys_clk); #1;
    checks += 3;
    if (m_axis_grant_base !== 10'd1000 || m_axis_grant_wrap !== 1'b1) begin
      errors++; $display("FAIL wrap_data: got base=%0d wrap=%0b expected base=1000 wrap=1", m_axis_grant_base, m_axis_grant_wrap);
    end
    drain();
    send(10, 3, 1);
    @(posedge sys_clk); #1;
    if (m_axis_grant_base !== 10'd26 || m_axis_grant_wrap !== 1'b0) begin
      errors++; $display("FAIL wrap_next: got base=%0d wrap=%0b expected base=26 wrap=0", m_axis_grant_base, m_axis_grant_wrap);
    end
    drain();
    if (source_available !== LW'(mfree)) begin errors++; $display("FAIL wrap_avail: got %0d expected %0d", source_available, mfree); end
  endtask
  task automatic test_starvation();
    int stall0;
    send(954, 4, 1);
    drain();
    stall0 = int'(stat_stall_cnt);
    send(20, 6, 1);
    repeat (6) @(posedge sys_clk);
    #1;
    checks += 5;
    if (m_axis_grant_valid !== 1'b0) begin errors++; $display("FAIL starve_valid: got %0b expected 0", m_axis_grant_valid); end
    if (source_available !== 11'd10) begin errors++; $display("FAIL starve_avail: got %0d expected 10", source_available); end
`ifdef SOURCE_POOL_STATS_EN
    if (int'(stat_stall_cnt) - stall0 != 5) begin errors++; $display("FAIL starve_stall: got %0d expected 5", int'(stat_stall_cnt) - stall0); end
`else
    if (int'(stat_stall_cnt) != stall0 || stall0 != 0) begin errors++; $display("FAIL starve_stall: got %0d expected 0", stat_stall_cnt); end
`endif
    rel(15);
    @(posedge sys_clk); #1;
    if (m_axis_grant_valid !== 1'b1) begin errors++; $display("FAIL starve_release: valid got %0b expected 1", m_axis_grant_valid); end
    if (source_available !== 11'd5) begin errors++; $display("FAIL starve_free: got %0d expected 5", source_available); end
    drain();
  endtask
  task automatic test_back_pressure();
    rel(1019);
    m_axis_grant_ready = 1'b0;
    send(30, 7, 1);
    send(40, 8, 1);
    send(10, 10, 1);
    send(99, 11, 0);
    checks += 5;
    if (s_axis_req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %0b expected 0", s_axis_req_ready); end
    repeat (10) @(posedge sys_clk);
    #1;
    if (m_axis_grant_valid !== 1'b1 || m_axis_grant_id !== 10'd7) begin
      errors++; $display("FAIL bp_hold: got valid=%0b id=%0d expected valid=1 id=7", m_axis_grant_valid, m_axis_grant_id);
    end
    if (source_available !== 11'd994) begin errors++; $display("FAIL bp_avail_hold: got %0d expected 994", source_available); end
    drain();
    repeat (3) @(posedge sys_clk);
    #1;
    if (s_axis_req_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_back: got %0b expected 1", s_axis_req_ready); end
    if (source_available !== LW'(mfree)) begin errors++; $display("FAIL bp_avail_drop: got %0d expected %0d", source_available, mfree); end
  endtask
  task automatic test_same_cycle();
    m_axis_grant_ready = 1'b0;
    send(30, 12, 1);
    rel(30);
    checks += 5;
    if (m_axis_grant_valid !== 1'b1) begin errors++; $display("FAIL same_valid: got %0b expected 1", m_axis_grant_valid); end
    if (source_available !== 11'd944) begin errors++; $display("FAIL same_avail: got %0d expected 944", source_available); end
    drain();
    rel(80);
    if (source_available !== 11'd1024 || rel_overflow_err !== 1'b0) begin
      errors++; $display("FAIL rel_full: got avail=%0d err=%0b expected 1024 and 0", source_available, rel_overflow_err);
    end
    rel(5);
    if (source_available !== 11'd1024) begin errors++; $display("FAIL rel_saturate: got %0d expected 1024", source_available); end
    @(posedge sys_clk); #1;
    if (rel_overflow_err !== 1'b1) begin errors++; $display("FAIL rel_overflow: got %0b expected 1", rel_overflow_err); end
  endtask
  task automatic test_zero_length();
    m_axis_grant_ready = 1'b1;
    send(0, 13, 1);
    @(posedge sys_clk); #1;
    checks += 4;
    if (m_axis_grant_valid !== 1'b1 || m_axis_grant_len !== 11'd0 || m_axis_grant_base !== 10'd96) begin
      errors++; $display("FAIL zero_grant: got valid=%0b len=%0d base=%0d expected 1/0/96", m_axis_grant_valid, m_axis_grant_len, m_axis_grant_base);
    end
    if (source_available !== 11'd1024) begin errors++; $display("FAIL zero_avail: got %0d expected 1024", source_available); end
    drain();
    send(1, 14, 1);
    drain();
    if (source_available !== 11'd1023) begin errors++; $display("FAIL zero_after: got %0d expected 1023", source_available); end
    if (rel_overflow_err !== 1'b1) begin errors++; $display("FAIL err_sticky: got %0b expected 1", rel_overflow_err); end
  endtask
  task automatic test_reset_mid();
    checks += 5;
`ifdef SOURCE_POOL_STATS_EN
    if (stat_grant_cnt !== 32'(grants)) begin errors++; $display("FAIL stat_grants: got %0d expected %0d", stat_grant_cnt, grants); end
`else
    if (stat_grant_cnt !== 32'd0) begin errors++; $display("FAIL stat_grants: got %0d expected 0", stat_grant_cnt); end
`endif
    m_axis_grant_ready = 1'b0;
    send(200, 15, 0);
    @(posedge sys_clk); #1;
    sys_rst = 1'b1;
    #1;
    if (m_axis_grant_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b expected 0", m_axis_grant_valid); end
    if (source_available !== 11'd1024) begin errors++; $display("FAIL rst_mid_avail: got %0d expected 1024", source_available); end
    if (rel_overflow_err !== 1'b0 || s_axis_req_ready !== 1'b1) begin
      errors++; $display("FAIL rst_mid_flags: got err=%0b ready=%0b expected 0 and 1", rel_overflow_err, s_axis_req_ready);
    end
    exp_q.delete();
    mptr   = 0;
    mfree  = PU;
    grants = 0;
    @(posedge sys_clk); #1;
    sys_rst = 1'b0;
    m_axis_grant_ready = 1'b1;
    send(100, 16, 1);
    drain();
    if (source_available !== 11'd924) begin errors++; $display("FAIL rst_mid_after: got %0d expected 924", source_available); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_starvation();
    test_back_pressure();
    test_same_cycle();
    test_zero_length();
    test_reset_mid();
    checks++;
    if (exp_q.size() != 0) begin errors++; $display("FAIL leftover_grants: got %0d pending expected 0", exp_q.size()); end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
